priority_span_decoder: RTL and testbench
========================================

PRIORITY_SPAN_DECODER -- requirements
Module: priority_span_decoder

Interface
REQ-001 Parameter WIDTH, default 16: width of the one-hot input masks, >= 2.
REQ-002 Parameter IDX_W, default $clog2(WIDTH): width of the index outputs.
REQ-003 Parameter CNT_W, default 8: width of the error counter.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 arstn_i  input  1  asynchronous active-low reset.
REQ-007 data_left_i  input  WIDTH  one-hot mask of the most significant set bit, as produced by priority_encoder data_left_o.
REQ-008 data_right_i  input  WIDTH  one-hot mask of the least significant set bit, as produced by priority_encoder data_right_o.
REQ-009 data_val_i  input  1  qualifies the masks for one cycle; no backpressure.
REQ-010 left_idx_o  output  IDX_W  bit position of data_left_i.
REQ-011 right_idx_o  output  IDX_W  bit position of data_right_i.
REQ-012 span_o  output  WIDTH  mask with ones from right_idx to left_idx inclusive.
REQ-013 span_len_o  output  IDX_W+1  left_idx - right_idx + 1.
REQ-014 empty_o  output  1  both input masks were zero.
REQ-015 err_o  output  1  input pair was malformed.
REQ-016 data_val_o  output  1  qualifies all result outputs for one cycle.
REQ-017 err_cnt_o  output  CNT_W  count of malformed valid inputs, saturating.

Function
REQ-018 Two-stage pipeline: stage 1 registers indices and classification; stage 2 registers span_o and span_len_o; latency is exactly 2 cycles, data_val_o = data_val_i delayed 2 cycles.
REQ-019 Full throughput: a new input is accepted every cycle data_val_i is high; back-to-back inputs produce back-to-back outputs in order.
REQ-020 Classification: both masks zero -> empty; both exactly one-hot and left position >= right position -> good; any other case -> error.
REQ-021 Error cases: either mask has more than one bit set, exactly one mask is zero, or left position < right position.
REQ-022 Good: indices hold the bit positions, span_o = contiguous mask, span_len_o = left_idx - right_idx + 1, empty_o = 0, err_o = 0.
REQ-023 Empty: indices 0, span_o 0, span_len_o 0, empty_o 1, err_o 0.
REQ-024 Error: indices 0, span_o 0, span_len_o 0, empty_o 0, err_o 1.
REQ-025 While data_val_o is 0, result outputs hold their last values; empty_o and err_o are 0.
REQ-026 Pipeline stages advance only with valid data; stage valid bits always advance.
REQ-027 err_cnt_o increments by 1 in the cycle err_o and data_val_o are both high; saturates at 2^CNT_W-1; it never wraps.
REQ-028 data_left_i, data_right_i are ignored when data_val_i is 0, including malformed values.

Reset
REQ-029 arstn_i low forces all outputs to 0 immediately, without waiting for a clock edge: indices, span, length, flags, data_val_o, err_cnt_o.
REQ-030 Reset mid-operation discards all in-flight data; no data_val_o pulse appears for inputs accepted before reset.
REQ-031 The first input accepted after arstn_i deasserts yields data_val_o exactly 2 cycles later.

Structure
REQ-032 A shared package priority_pkg holds a typedef for the classification enum (GOOD, EMPTY, ERROR) and the default WIDTH constant; priority_encoder and this block use it.
REQ-033 One sub-module, onehot_to_idx, instantiated twice: it converts one mask to an index plus flags for zero and more-than-one-bit-set.

Verification (WIDTH=16)
REQ-034 left 0x0800, right 0x0040, val 1 -> 2 cycles later: left_idx 11, right_idx 6, span 0x0FC0, len 6, err 0, val_o 1.
REQ-035 left 0x8000, right 0x8000 -> left_idx 15, right_idx 15, span 0x8000, len 1; left 0x0000, right 0x0000 -> empty_o 1, span 0, len 0.
REQ-036 Errors: left 0x0003 / right 0x0001; left 0x0010 / right 0x0000; left 0x0001 / right 0x0100 -> err_o 1 each, outputs 0, err_cnt_o increments 0->1->2->3.
REQ-037 Bench drives 20 random good pairs back-to-back -> 20 consecutive val_o pulses, in order, matching a scoreboard model; 300 error inputs -> err_cnt_o ends at 255.
REQ-038 Bench asserts arstn_i low between clock edges with 2 inputs in flight -> outputs 0 at once, no val_o after release; the next input yields val_o 2 cycles later.

Source files
------------

// File: rtl/priority_pkg.sv
// Shared types for the priority encoder family: mask classification and default width.
// Latency: none (package only).
// Backpressure: none (package only).
package priority_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Outcome of checking a left/right one-hot mask pair.
    typedef enum logic [1:0] {
        GOOD  = 2'd0,
        EMPTY = 2'd1,
        ERROR = 2'd2
    } cls_e;

endpackage

// File: rtl/onehot_to_idx.sv
// Converts one one-hot mask to a bit index, with flags for an all-zero mask and for more than one bit set.
// Latency: combinational.
// Backpressure: none; output follows the input mask directly.
module onehot_to_idx #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             zero_o,
    output logic             multi_o
);

    logic seen;

    // Scan the mask: OR together the positions of set bits and flag a second set bit.
    always_comb begin
        idx_o   = '0;
        multi_o = 1'b0;
        seen    = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mask_i[i]) begin
                if (seen) begin
                    multi_o = 1'b1;
                end
                seen  = 1'b1;
                idx_o = idx_o | IDX_W'(i);
            end
        end
        zero_o = ~seen;
    end

endmodule

// File: rtl/priority_span_decoder.sv
// Decodes a left/right one-hot mask pair into indices, a contiguous span mask, its length and error/empty flags.
// Latency: exactly 2 cycles from data_val_i to data_val_o, full throughput.
// Backpressure: none; every valid input produces a result, invalid cycles are ignored.
module priority_span_decoder
    import priority_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic [WIDTH-1:0] data_left_i,
    input  logic [WIDTH-1:0] data_right_i,
    input  logic             data_val_i,
    output logic [IDX_W-1:0] left_idx_o,
    output logic [IDX_W-1:0] right_idx_o,
    output logic [WIDTH-1:0] span_o,
    output logic [IDX_W:0]   span_len_o,
    output logic             empty_o,
    output logic             err_o,
    output logic             data_val_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    // Mask-to-index conversion for both inputs.
    logic [IDX_W-1:0] l_idx, r_idx;
    logic             l_zero, r_zero, l_multi, r_multi;

    onehot_to_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_left (
        .mask_i  (data_left_i),
        .idx_o   (l_idx),
        .zero_o  (l_zero),
        .multi_o (l_multi)
    );

    onehot_to_idx #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_right (
        .mask_i  (data_right_i),
        .idx_o   (r_idx),
        .zero_o  (r_zero),
        .multi_o (r_multi)
    );

    // Stage 1 next-state: classification and indices (indices forced to 0 unless the pair is good).
    cls_e             cls_d;
    logic [IDX_W-1:0] s1_lidx_d, s1_ridx_d;

    // Classify the incoming pair: both zero is empty, two clean one-hots in order is good, anything else is an error.
    always_comb begin
        cls_d     = ERROR;
        s1_lidx_d = '0;
        s1_ridx_d = '0;
        if (l_zero && r_zero) begin
            cls_d = EMPTY;
        end else if (!l_zero && !r_zero && !l_multi && !r_multi && (l_idx >= r_idx)) begin
            cls_d     = GOOD;
            s1_lidx_d = l_idx;
            s1_ridx_d = r_idx;
        end
    end

    logic             s1_vld_q;
    cls_e             s1_cls_q;
    logic [IDX_W-1:0] s1_lidx_q, s1_ridx_q;

    // Stage 1 register: valid always advances, payload only loads on a valid input.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            s1_vld_q  <= 1'b0;
            s1_cls_q  <= EMPTY;
            s1_lidx_q <= '0;
            s1_ridx_q <= '0;
        end else begin
            s1_vld_q <= data_val_i;
            if (data_val_i) begin
                s1_cls_q  <= cls_d;
                s1_lidx_q <= s1_lidx_d;
                s1_ridx_q <= s1_ridx_d;
            end
        end
    end

    // Stage 2 next-state: span mask and length, zero unless stage 1 holds a good pair.
    logic             s1_good;
    logic [WIDTH-1:0] span_d;
    logic [IDX_W:0]   len_d;

    assign s1_good = (s1_cls_q == GOOD);

    // Build the contiguous mask between the two indices and its inclusive length.
    always_comb begin
        span_d = '0;
        len_d  = '0;
        if (s1_good) begin
            for (int i = 0; i < WIDTH; i++) begin
                span_d[i] = (IDX_W'(i) >= s1_ridx_q) && (IDX_W'(i) <= s1_lidx_q);
            end
            len_d = {1'b0, s1_lidx_q} - {1'b0, s1_ridx_q} + (IDX_W+1)'(1);
        end
    end

    logic             val_q, empty_q, err_q;
    logic [IDX_W-1:0] lidx_q, ridx_q;
    logic [WIDTH-1:0] span_q;
    logic [IDX_W:0]   len_q;
    logic [CNT_W-1:0] cnt_q;

    // Stage 2 register: results hold between valid cycles, flags drop to 0 when nothing is valid,
    // and the error counter moves in the same cycle the error result is presented.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            val_q   <= 1'b0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
            lidx_q  <= '0;
            ridx_q  <= '0;
            span_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            val_q   <= s1_vld_q;
            empty_q <= s1_vld_q && (s1_cls_q == EMPTY);
            err_q   <= s1_vld_q && (s1_cls_q == ERROR);
            if (s1_vld_q) begin
                lidx_q <= s1_lidx_q;
                ridx_q <= s1_ridx_q;
                span_q <= span_d;
                len_q  <= len_d;
            end
            if (s1_vld_q && (s1_cls_q == ERROR) && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign left_idx_o  = lidx_q;
    assign right_idx_o = ridx_q;
    assign span_o      = span_q;
    assign span_len_o  = len_q;
    assign empty_o     = empty_q;
    assign err_o       = err_q;
    assign data_val_o  = val_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: tb/tb_priority_span_decoder.sv
// Directed table vectors plus hand-written sequences for back-to-back, saturation and reset cases.
// Latency: checks data_val_o exactly 2 cycles after each accepted input.
// Backpressure: none; inputs are driven every cycle as required.
module tb_priority_span_decoder;

    localparam int W  = 16;
    localparam int IW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          arstn;
    logic [W-1:0]  dl, dr;
    logic          dv;
    logic [IW-1:0] lidx, ridx;
    logic [W-1:0]  span;
    logic [IW:0]   slen;
    logic          empty, err, vo;
    logic [CW-1:0] cnt;

    priority_span_decoder #(.WIDTH(W), .IDX_W(IW), .CNT_W(CW)) dut (
        .clk_i        (clk),
        .arstn_i      (arstn),
        .data_left_i  (dl),
        .data_right_i (dr),
        .data_val_i   (dv),
        .left_idx_o   (lidx),
        .right_idx_o  (ridx),
        .span_o       (span),
        .span_len_o   (slen),
        .empty_o      (empty),
        .err_o        (err),
        .data_val_o   (vo),
        .err_cnt_o    (cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           li;
        int           ri;
        logic [W-1:0] sp;
        int           len;
        bit           emp;
        bit           er;
        int           cnt;
    } vec_t;

    function automatic logic [W-1:0] span_model(input int l, input int r);
        logic [W-1:0] m;
        m = '0;
        for (int i = r; i <= l; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " val_o"},  {31'd0, vo},    32'd1);
        check({tag, " lidx"},   {28'd0, lidx},  v.li);
        check({tag, " ridx"},   {28'd0, ridx},  v.ri);
        check({tag, " span"},   {16'd0, span},  {16'd0, v.sp});
        check({tag, " len"},    {27'd0, slen},  v.len);
        check({tag, " empty"},  {31'd0, empty}, {31'd0, v.emp});
        check({tag, " err"},    {31'd0, err},   {31'd0, v.er});
        check({tag, " errcnt"}, {24'd0, cnt},   v.cnt);
    endtask

    vec_t tbl[9];
    vec_t rq[20];
    vec_t v;

    initial begin
        tbl[0] = '{16'h0800, 16'h0040, 11,  6, 16'h0FC0,  6, 1'b0, 1'b0, 0};
        tbl[1] = '{16'h8000, 16'h8000, 15, 15, 16'h8000,  1, 1'b0, 1'b0, 0};
        tbl[2] = '{16'h0000, 16'h0000,  0,  0, 16'h0000,  0, 1'b1, 1'b0, 0};
        tbl[3] = '{16'h0003, 16'h0001,  0,  0, 16'h0000,  0, 1'b0, 1'b1, 1};
        tbl[4] = '{16'h0010, 16'h0000,  0,  0, 16'h0000,  0, 1'b0, 1'b1, 2};
        tbl[5] = '{16'h0001, 16'h0100,  0,  0, 16'h0000,  0, 1'b0, 1'b1, 3};
        tbl[6] = '{16'h0001, 16'h0001,  0,  0, 16'h0001,  1, 1'b0, 1'b0, 3};
        tbl[7] = '{16'h8000, 16'h0001, 15,  0, 16'hFFFF, 16, 1'b0, 1'b0, 3};
        tbl[8] = '{16'h0000, 16'h0004,  0,  0, 16'h0000,  0, 1'b0, 1'b1, 4};

        // Reset state.
        arstn = 1'b0; dv = 1'b0; dl = '0; dr = '0;
        #1;
        check("reset val_o", {31'd0, vo}, 32'd0);
        check("reset outputs", {lidx, ridx, span, slen, empty, err},
              32'd0);
        check("reset errcnt", {24'd0, cnt}, 32'd0);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk);

        // Table vectors, each applied alone; result is checked 2 edges later, then the hold cycle.
        for (int k = 0; k < 9; k++) begin
            dl = tbl[k].l; dr = tbl[k].r; dv = 1'b1;
            @(negedge clk);
            dv = 1'b0; dl = 16'h0003; dr = 16'h0000;
            check($sformatf("vec%0d early val_o", k), {31'd0, vo}, 32'd0);
            @(negedge clk);
            check_all($sformatf("vec%0d", k), tbl[k]);
            @(negedge clk);
            check($sformatf("vec%0d idle val_o", k), {31'd0, vo}, 32'd0);
            check($sformatf("vec%0d idle flags", k), {30'd0, empty, err}, 32'd0);
            check($sformatf("vec%0d hold span", k), {16'd0, span}, {16'd0, tbl[k].sp});
        end

        // Malformed data with data_val_i low must be ignored entirely.
        dv = 1'b0; dl = 16'hFFFF; dr = 16'h0001;
        repeat (4) @(negedge clk);
        check("ignored val_o", {31'd0, vo}, 32'd0);
        check("ignored errcnt", {24'd0, cnt}, 32'd4);

        // 20 random good pairs back-to-back.
        for (int j = 0; j < 20; j++) begin
            rq[j].li  = $urandom_range(15, 0);
            rq[j].ri  = $urandom_range(rq[j].li, 0);
            rq[j].l   = 16'h0001 << rq[j].li;
            rq[j].r   = 16'h0001 << rq[j].ri;
            rq[j].sp  = span_model(rq[j].li, rq[j].ri);
            rq[j].len = rq[j].li - rq[j].ri + 1;
            rq[j].emp = 1'b0;
            rq[j].er  = 1'b0;
            rq[j].cnt = 4;
        end
        for (int j = 0; j < 22; j++) begin
            if (j >= 2) check_all($sformatf("b2b%0d", j - 2), rq[j - 2]);
            if (j < 20) begin
                dl = rq[j].l; dr = rq[j].r; dv = 1'b1;
            end else begin
                dv = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b drained val_o", {31'd0, vo}, 32'd0);

        // 300 malformed inputs: counter saturates at 255 while err_o keeps pulsing.
        dl = 16'h0003; dr = 16'h0001;
        for (int j = 0; j < 300; j++) begin
            dv = 1'b1;
            @(negedge clk);
        end
        check("sat err_o", {31'd0, err}, 32'd1);
        check("sat errcnt mid", {24'd0, cnt}, 32'd255);
        dv = 1'b0;
        repeat (3) @(negedge clk);
        check("sat errcnt final", {24'd0, cnt}, 32'd255);

        // Reset between edges with two good inputs in flight.
        dl = 16'h0800; dr = 16'h0040; dv = 1'b1;
        @(negedge clk);
        dl = 16'h0100; dr = 16'h0010; dv = 1'b1;
        @(posedge clk);
        #2;
        dv = 1'b0;
        arstn = 1'b0;
        #1;
        check("midrst val_o", {31'd0, vo}, 32'd0);
        check("midrst outputs", {lidx, ridx, span, slen, empty, err}, 32'd0);
        check("midrst errcnt", {24'd0, cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (vo) seen++;
            end
            check("post-rst stray val_o", seen, 32'd0);
        end

        // First input after release appears exactly 2 cycles later.
        v = '{16'h0020, 16'h0004, 5, 2, 16'h003C, 4, 1'b0, 1'b0, 0};
        dl = v.l; dr = v.r; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        check("post-rst early val_o", {31'd0, vo}, 32'd0);
        @(negedge clk);
        check_all("post-rst", v);
        @(negedge clk);
        check("post-rst idle val_o", {31'd0, vo}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
